// File: rtl/nn_call_sequencer.sv
// Sequencer that launches one neural-network core call per control tick,
// holds the operands stable for the call, waits for the result with a
// timeout, and publishes a clamped result with a one-cycle valid pulse.
module nn_call_sequencer #(
    parameter int unsigned        PULSE_LEN = 2,
    parameter int unsigned        TIMEOUT   = 255,
    parameter logic signed [15:0] U_MIN     = 16'sh8001,
    parameter logic signed [15:0] U_MAX     = 16'sh7FFF
) (
    input  logic               clk_1,
    input  logic               ap_rst_n,
    input  logic               ce_1,
    input  logic               trig,
    input  logic signed [15:0] r_in,
    input  logic signed [15:0] pos_in,
    input  logic signed [15:0] vel_in,
    input  logic               clr_flags,
    output logic               ap_start,
    output logic               fc0_input_ap_vld,
    output logic signed [15:0] r,
    output logic signed [15:0] pos,
    output logic signed [15:0] vel,
    input  logic               ap_done,
    input  logic               ap_idle,
    input  logic               layer13_out_ap_vld,
    input  logic signed [15:0] layer13_out,
    output logic signed [15:0] u_out,
    output logic               u_vld,
    output logic               busy,
    output logic               overrun,
    output logic               timeout,
    output logic               no_data
);

    localparam int unsigned PW = $clog2(PULSE_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                 start_q, start_d;
    logic signed [15:0]   r_q, r_d, pos_q, pos_d, vel_q, vel_d;
    logic signed [15:0]   result_q, result_d;
    logic                 got_data_q, got_data_d;
    logic signed [15:0]   u_out_q, u_out_d;
    logic                 u_vld_q, u_vld_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic                 no_data_q, no_data_d;
    logic                 ovr_set, tmo_set, nod_set;

    function automatic logic signed [15:0] clamp(input logic signed [15:0] v);
        if (v > U_MAX) begin
            return U_MAX;
        end else if (v < U_MIN) begin
            return U_MIN;
        end
        return v;
    endfunction

    // Next-state logic; with ce_1 low every register holds its value.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        start_d     = start_q;
        r_d         = r_q;
        pos_d       = pos_q;
        vel_d       = vel_q;
        result_d    = result_q;
        got_data_d  = got_data_q;
        u_out_d     = u_out_q;
        u_vld_d     = u_vld_q;
        ovr_set     = 1'b0;
        tmo_set     = 1'b0;
        nod_set     = 1'b0;
        if (ce_1) begin
            u_vld_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (trig) begin
                        if (ap_idle) begin
                            r_d         = r_in;
                            pos_d       = pos_in;
                            vel_d       = vel_in;
                            pulse_cnt_d = PW'(PULSE_LEN);
                            start_d     = 1'b1;
                            state_d     = StLaunch;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end
                end
                StLaunch: begin
                    ovr_set = trig;
                    if (pulse_cnt_q <= PW'(1)) begin
                        start_d     = 1'b0;
                        pulse_cnt_d = '0;
                        tmo_cnt_d   = '0;
                        state_d     = StWait;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q - 1'b1;
                    end
                end
                StWait: begin
                    ovr_set = trig;
                    if (layer13_out_ap_vld) begin
                        result_d   = layer13_out;
                        got_data_d = 1'b1;
                    end
                    // Same-cycle vld+done uses this cycle's data via the _d values.
                    if (ap_done) begin
                        state_d = StDone;
                        if (got_data_d) begin
                            u_out_d = clamp(result_d);
                            u_vld_d = 1'b1;
                        end else begin
                            nod_set = 1'b1;
                        end
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                        if (tmo_cnt_d == TW'(TIMEOUT)) begin
                            tmo_set    = 1'b1;
                            tmo_cnt_d  = '0;
                            got_data_d = 1'b0;
                            state_d    = StIdle;
                        end
                    end
                end
                StDone: begin
                    ovr_set    = trig;
                    got_data_d = 1'b0;
                    state_d    = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
        busy_d    = (state_d != StIdle);
        // Set beats clear when both land in the same cycle.
        overrun_d = ovr_set | (overrun_q & ~(ce_1 & clr_flags));
        timeout_d = tmo_set | (timeout_q & ~(ce_1 & clr_flags));
        no_data_d = nod_set | (no_data_q & ~(ce_1 & clr_flags));
    end

    // State and registered outputs; reset drops ap_start immediately.
    always_ff @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            pulse_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            start_q     <= 1'b0;
            r_q         <= '0;
            pos_q       <= '0;
            vel_q       <= '0;
            result_q    <= '0;
            got_data_q  <= 1'b0;
            u_out_q     <= '0;
            u_vld_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            no_data_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            start_q     <= start_d;
            r_q         <= r_d;
            pos_q       <= pos_d;
            vel_q       <= vel_d;
            result_q    <= result_d;
            got_data_q  <= got_data_d;
            u_out_q     <= u_out_d;
            u_vld_q     <= u_vld_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            no_data_q   <= no_data_d;
        end
    end

    assign ap_start         = start_q;
    assign fc0_input_ap_vld = start_q;
    assign r                = r_q;
    assign pos              = pos_q;
    assign vel              = vel_q;
    assign u_out            = u_out_q;
    assign u_vld            = u_vld_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;
    assign timeout          = timeout_q;
    assign no_data          = no_data_q;

endmodule

// File: tb/tb_nn_call_sequencer.sv
// Bench for nn_call_sequencer: two instances (default limits, and a narrow
// U_MAX with a short timeout) share one stimulus stream and are compared
// every cycle against a call-level model, plus directed literal checks.
module tb_nn_call_sequencer;

    localparam int PL   = 2;
    localparam int UMIN = -32767;

    int umax [2] = '{32767, 1024};
    int tmo  [2] = '{255, 10};

    logic        clk_1 = 1'b0;
    logic        ap_rst_n, ce_1, trig, clr_flags, ap_done, ap_idle, vld_in;
    logic [15:0] r_in, pos_in, vel_in, layer13_out;

    logic [1:0]  st_w, fc_w, uv_w, busy_w, ov_w, to_w, nd_w;
    logic [15:0] r_w [2];
    logic [15:0] pos_w [2];
    logic [15:0] vel_w [2];
    logic [15:0] u_w [2];

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int vld_cnt = 0;

    always #5 clk_1 = ~clk_1;

    nn_call_sequencer u_dut0 (
        .clk_1(clk_1), .ap_rst_n(ap_rst_n), .ce_1(ce_1), .trig(trig),
        .r_in(r_in), .pos_in(pos_in), .vel_in(vel_in), .clr_flags(clr_flags),
        .ap_start(st_w[0]), .fc0_input_ap_vld(fc_w[0]),
        .r(r_w[0]), .pos(pos_w[0]), .vel(vel_w[0]),
        .ap_done(ap_done), .ap_idle(ap_idle), .layer13_out_ap_vld(vld_in),
        .layer13_out(layer13_out), .u_out(u_w[0]), .u_vld(uv_w[0]),
        .busy(busy_w[0]), .overrun(ov_w[0]), .timeout(to_w[0]), .no_data(nd_w[0])
    );

    nn_call_sequencer #(
        .PULSE_LEN(2), .TIMEOUT(10), .U_MIN(16'sh8001), .U_MAX(16'sh0400)
    ) u_dut1 (
        .clk_1(clk_1), .ap_rst_n(ap_rst_n), .ce_1(ce_1), .trig(trig),
        .r_in(r_in), .pos_in(pos_in), .vel_in(vel_in), .clr_flags(clr_flags),
        .ap_start(st_w[1]), .fc0_input_ap_vld(fc_w[1]),
        .r(r_w[1]), .pos(pos_w[1]), .vel(vel_w[1]),
        .ap_done(ap_done), .ap_idle(ap_idle), .layer13_out_ap_vld(vld_in),
        .layer13_out(layer13_out), .u_out(u_w[1]), .u_vld(uv_w[1]),
        .busy(busy_w[1]), .overrun(ov_w[1]), .timeout(to_w[1]), .no_data(nd_w[1])
    );

    // Call-level model: a call is "busy" from launch; age counts enabled
    // cycles since launch, so the first PL ages are the start pulse.
    bit          m_busy [2], m_fin [2], m_has [2], m_vld [2];
    bit          m_ov [2], m_to [2], m_nd [2];
    int          m_age [2];
    logic [15:0] m_r [2], m_pos [2], m_vel [2], m_res [2], m_u [2];
    bit          e_ov, e_to, e_nd;

    function automatic logic [15:0] mclamp(input logic [15:0] v, input int hi);
        int s;
        s = int'($signed(v));
        if (s > hi) s = hi;
        if (s < UMIN) s = UMIN;
        return s[15:0];
    endfunction

    always @(posedge clk_1 or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_fin[i] = 0; m_has[i] = 0; m_vld[i] = 0;
                m_ov[i] = 0; m_to[i] = 0; m_nd[i] = 0; m_age[i] = 0;
                m_r[i] = '0; m_pos[i] = '0; m_vel[i] = '0; m_res[i] = '0; m_u[i] = '0;
            end
        end else if (ce_1) begin
            for (int i = 0; i < 2; i++) begin
                e_ov = trig && (m_busy[i] || !ap_idle);
                e_to = 0;
                e_nd = 0;
                m_vld[i] = 0;
                if (!m_busy[i]) begin
                    if (trig && ap_idle) begin
                        m_r[i] = r_in; m_pos[i] = pos_in; m_vel[i] = vel_in;
                        m_busy[i] = 1; m_age[i] = 0; m_has[i] = 0; m_fin[i] = 0;
                    end
                end else if (m_fin[i]) begin
                    m_busy[i] = 0;
                    m_fin[i] = 0;
                end else if (m_age[i] < PL) begin
                    m_age[i]++;
                end else begin
                    if (vld_in) begin
                        m_res[i] = layer13_out;
                        m_has[i] = 1;
                    end
                    if (ap_done) begin
                        m_fin[i] = 1;
                        if (m_has[i]) begin
                            m_u[i] = mclamp(m_res[i], umax[i]);
                            m_vld[i] = 1;
                        end else begin
                            e_nd = 1;
                        end
                    end else if (m_age[i] - PL + 1 == tmo[i]) begin
                        e_to = 1;
                        m_busy[i] = 0;
                    end else begin
                        m_age[i]++;
                    end
                end
                m_ov[i] = e_ov || (m_ov[i] && !clr_flags);
                m_to[i] = e_to || (m_to[i] && !clr_flags);
                m_nd[i] = e_nd || (m_nd[i] && !clr_flags);
            end
        end
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_1) begin
        for (int i = 0; i < 2; i++) begin
            chk("ap_start", i, 32'(st_w[i]), 32'(m_busy[i] && m_age[i] < PL));
            chk("fc0_vld", i, 32'(fc_w[i]), 32'(m_busy[i] && m_age[i] < PL));
            chk("busy", i, 32'(busy_w[i]), 32'(m_busy[i]));
            chk("u_vld", i, 32'(uv_w[i]), 32'(m_vld[i]));
            chk("u_out", i, 32'(u_w[i]), 32'(m_u[i]));
            chk("r", i, 32'(r_w[i]), 32'(m_r[i]));
            chk("pos", i, 32'(pos_w[i]), 32'(m_pos[i]));
            chk("vel", i, 32'(vel_w[i]), 32'(m_vel[i]));
            chk("overrun", i, 32'(ov_w[i]), 32'(m_ov[i]));
            chk("timeout", i, 32'(to_w[i]), 32'(m_to[i]));
            chk("no_data", i, 32'(nd_w[i]), 32'(m_nd[i]));
        end
        if (st_w[0]) start_cnt++;
        if (uv_w[0]) vld_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_1);
            #1;
        end
    endtask

    task automatic call(input logic [15:0] d, input int dly, input bit with_vld);
        trig = 1; cyc(1); trig = 0;
        cyc(dly - 1);
        ap_done = 1; vld_in = with_vld; layer13_out = d;
        cyc(1);
        ap_done = 0; vld_in = 0;
        cyc(3);
    endtask

    int s0, v0;

    initial begin
        ap_rst_n = 0; ce_1 = 1; trig = 0; clr_flags = 0; ap_done = 0; ap_idle = 1;
        vld_in = 0; r_in = '0; pos_in = '0; vel_in = '0; layer13_out = '0;
        cyc(3);
        lit("rst_ap_start", 32'(st_w[0]), 32'd0);
        lit("rst_busy", 32'(busy_w[0]), 32'd0);
        lit("rst_u_out", 32'(u_w[0]), 32'd0);
        lit("rst_overrun", 32'(ov_w[1]), 32'd0);
        ap_rst_n = 1;
        cyc(2);

        // Basic call: result 0x1234 six cycles after trig.
        r_in = 16'h0100; pos_in = 16'h0020; vel_in = 16'hFFF0;
        s0 = start_cnt; v0 = vld_cnt;
        trig = 1; cyc(1); trig = 0;
        r_in = 16'hAAAA; pos_in = 16'hBBBB; vel_in = 16'hCCCC;
        cyc(5);
        ap_done = 1; vld_in = 1; layer13_out = 16'h1234;
        cyc(1);
        ap_done = 0; vld_in = 0;
        lit("t1_u_vld", 32'(uv_w[0]), 32'd1);
        cyc(3);
        lit("t1_u_out0", 32'(u_w[0]), 32'h1234);
        lit("t1_u_out1", 32'(u_w[1]), 32'h0400);
        lit("t1_start_len", 32'(start_cnt - s0), 32'd2);
        lit("t1_vld_pulses", 32'(vld_cnt - v0), 32'd1);
        lit("t1_r", 32'(r_w[0]), 32'h0100);
        lit("t1_pos", 32'(pos_w[0]), 32'h0020);
        lit("t1_vel", 32'(vel_w[0]), 32'hFFF0);
        lit("t1_busy", 32'(busy_w[0]), 32'd0);

        // Clamp limits.
        call(16'h7000, 4, 1);
        lit("clamp_hi0", 32'(u_w[0]), 32'h7000);
        lit("clamp_hi1", 32'(u_w[1]), 32'h0400);
        call(16'h8000, 4, 1);
        lit("clamp_lo0", 32'(u_w[0]), 32'h8001);
        lit("clamp_lo1", 32'(u_w[1]), 32'h8001);

        // Core never finishes: short-timeout instance gives up first.
        v0 = vld_cnt;
        trig = 1; cyc(1); trig = 0;
        cyc(12);
        lit("tmo_flag1", 32'(to_w[1]), 32'd1);
        lit("tmo_idle1", 32'(busy_w[1]), 32'd0);
        lit("tmo_busy0", 32'(busy_w[0]), 32'd1);
        lit("tmo_flag0_early", 32'(to_w[0]), 32'd0);
        cyc(250);
        lit("tmo_flag0", 32'(to_w[0]), 32'd1);
        lit("tmo_idle0", 32'(busy_w[0]), 32'd0);
        lit("tmo_no_vld", 32'(vld_cnt - v0), 32'd0);
        call(16'h0100, 3, 1);
        lit("after_tmo_u0", 32'(u_w[0]), 32'h0100);
        lit("after_tmo_u1", 32'(u_w[1]), 32'h0100);
        lit("after_tmo_vld", 32'(vld_cnt - v0), 32'd1);

        // Overrun: trig during WAIT, then trig with core not idle.
        clr_flags = 1; cyc(1); clr_flags = 0;
        lit("clr_timeout", 32'(to_w[0]), 32'd0);
        s0 = start_cnt;
        trig = 1; cyc(1); trig = 0;
        cyc(3);
        trig = 1; cyc(1); trig = 0;
        lit("ovr_wait", 32'(ov_w[0]), 32'd1);
        cyc(1);
        ap_done = 1; vld_in = 1; layer13_out = 16'h0055;
        cyc(1);
        ap_done = 0; vld_in = 0;
        cyc(3);
        lit("ovr_one_launch", 32'(start_cnt - s0), 32'd2);
        lit("ovr_u_out", 32'(u_w[0]), 32'h0055);
        clr_flags = 1; cyc(1); clr_flags = 0;
        lit("ovr_cleared", 32'(ov_w[0]), 32'd0);
        r_in = 16'hBEEF; ap_idle = 0;
        trig = 1; cyc(1); trig = 0;
        lit("ovr_not_idle", 32'(ov_w[0]), 32'd1);
        lit("ovr_no_launch", 32'(busy_w[0]), 32'd0);
        lit("ovr_r_kept", 32'(r_w[0]), 32'hAAAA);
        clr_flags = 1; trig = 1; cyc(1); clr_flags = 0; trig = 0;
        lit("ovr_set_wins", 32'(ov_w[0]), 32'd1);
        clr_flags = 1; cyc(1); clr_flags = 0;
        lit("ovr_clear2", 32'(ov_w[1]), 32'd0);
        ap_idle = 1;

        // Done without data.
        v0 = vld_cnt;
        call(16'h7777, 3, 0);
        lit("nd_flag", 32'(nd_w[0]), 32'd1);
        lit("nd_u_kept", 32'(u_w[0]), 32'h0055);
        lit("nd_no_vld", 32'(vld_cnt - v0), 32'd0);

        // Reset during LAUNCH.
        trig = 1; cyc(1); trig = 0;
        lit("rl_launching", 32'(st_w[0]), 32'd1);
        ap_rst_n = 0;
        #1;
        lit("rl_start_drop", 32'(st_w[0]), 32'd0);
        lit("rl_busy_drop", 32'(busy_w[1]), 32'd0);
        lit("rl_u_out", 32'(u_w[0]), 32'd0);
        lit("rl_no_data", 32'(nd_w[0]), 32'd0);
        cyc(2);
        ap_rst_n = 1;
        s0 = start_cnt;
        cyc(4);
        lit("rl_no_reissue", 32'(start_cnt - s0), 32'd0);
        lit("rl_idle", 32'(busy_w[0]), 32'd0);

        // Clock enable low for 3 cycles mid-pulse stretches ap_start.
        s0 = start_cnt;
        trig = 1; cyc(1); trig = 0;
        ce_1 = 0; cyc(3); ce_1 = 1;
        cyc(4);
        lit("ce_start_len", 32'(start_cnt - s0), 32'd5);
        ap_done = 1; vld_in = 1; layer13_out = 16'h0123;
        cyc(1);
        ap_done = 0; vld_in = 0;
        cyc(3);
        lit("ce_u_out", 32'(u_w[0]), 32'h0123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
